// File: rtl/reg_scoreboard.sv
// Register-result scoreboard for the ID stage: tracks per-GPR forwarding readiness and
// outstanding long-unit (mul/div) results, and stalls ID until every source can be served.
module reg_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ID_Valid,
  input  logic [4:0]      ID_rs,
  input  logic [4:0]      ID_rt,
  input  logic            ID_UseRs,
  input  logic            ID_UseRt,
  input  logic            ID_WrEn,
  input  logic [4:0]      ID_Dst,
  input  logic [CNTW-1:0] ID_Lat,
  input  logic            ID_Long,
  input  logic            LongDone,
  input  logic [4:0]      LongDst,
  input  logic            Flush,
  output logic            ID_Stall,
  output logic            ID_Fire,
  output logic            LongBusy
);

  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [NREG-1:0] lbusy_q, lbusy_d;
  logic            lpend_q, lpend_d;

  logic haz_a, haz_b, waw_l, struct_l, wr_issue;

  // Register 0 and any index beyond NREG are never tracked.
  function automatic logic tracked(input logic [4:0] r);
    return (r != 5'd0) && (32'(r) < NREG);
  endfunction

  // Stall terms look only at registered state, so an issue never blocks itself.
  assign haz_a    = ID_UseRs && tracked(ID_rs) && ((cnt_q[ID_rs] != '0) || lbusy_q[ID_rs]);
  assign haz_b    = ID_UseRt && tracked(ID_rt) && ((cnt_q[ID_rt] != '0) || lbusy_q[ID_rt]);
  assign waw_l    = ID_WrEn && tracked(ID_Dst) && lbusy_q[ID_Dst];
  assign struct_l = ID_Long && lpend_q;

  assign ID_Stall = ID_Valid & (haz_a | haz_b | waw_l | struct_l);
  assign ID_Fire  = ID_Valid & ~ID_Stall & ~Flush;
  assign LongBusy = lpend_q;
  assign wr_issue = ID_Fire & ID_WrEn & tracked(ID_Dst);

  always_comb begin
    lbusy_d = lbusy_q;
    lpend_d = lpend_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNTW'(1) : '0;
    end

    if (LongDone) begin
      lpend_d = 1'b0;
      if (tracked(LongDst)) lbusy_d[LongDst] = 1'b0;
    end

    if (ID_Fire && ID_Long) lpend_d = 1'b1;

    // The younger issue overrides any decrement of the same register.
    if (wr_issue) begin
      if (ID_Long) begin
        lbusy_d[ID_Dst] = 1'b1;
        cnt_d[ID_Dst]   = '0;
      end else begin
        cnt_d[ID_Dst]   = ID_Lat;
      end
    end

    // Flush aborts the long unit too, so a coincident LongDone is moot.
    if (Flush) begin
      lpend_d = 1'b0;
      lbusy_d = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '{default: '0};
      lbusy_q <= '0;
      lpend_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lbusy_q <= lbusy_d;
      lpend_q <= lpend_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus randomized traffic checked against a
// model that tracks the absolute cycle at which each register becomes forwardable.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       ID_Valid, ID_UseRs, ID_UseRt, ID_WrEn, ID_Long, LongDone, Flush;
  logic [4:0] ID_rs, ID_rt, ID_Dst, LongDst;
  logic [1:0] ID_Lat;
  logic       ID_Stall, ID_Fire, LongBusy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: ready_at[r] is the edge count from which a consumer of r may issue.
  int ready_at [32];
  bit lb_m     [32];
  bit lp_m;
  int now_e;
  int ldst_m;

  reg_scoreboard #(.NREG(32), .CNTW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ID_Valid (ID_Valid),
    .ID_rs    (ID_rs),
    .ID_rt    (ID_rt),
    .ID_UseRs (ID_UseRs),
    .ID_UseRt (ID_UseRt),
    .ID_WrEn  (ID_WrEn),
    .ID_Dst   (ID_Dst),
    .ID_Lat   (ID_Lat),
    .ID_Long  (ID_Long),
    .LongDone (LongDone),
    .LongDst  (LongDst),
    .Flush    (Flush),
    .ID_Stall (ID_Stall),
    .ID_Fire  (ID_Fire),
    .LongBusy (LongBusy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      ready_at[r] = 0;
      lb_m[r]     = 1'b0;
    end
    lp_m   = 1'b0;
    now_e  = 0;
    ldst_m = 0;
  endtask

  function automatic bit m_haz(input logic [4:0] r, input logic use_r);
    return use_r && (r != 0) && ((ready_at[r] > now_e) || lb_m[r]);
  endfunction

  function automatic bit m_stall();
    return ID_Valid && (m_haz(ID_rs, ID_UseRs) || m_haz(ID_rt, ID_UseRt) ||
                        (ID_WrEn && ID_Dst != 0 && lb_m[ID_Dst]) || (ID_Long && lp_m));
  endfunction

  task automatic model_update();
    bit fire;
    fire  = ID_Valid && !m_stall() && !Flush;
    now_e = now_e + 1;
    if (Flush) begin
      for (int r = 0; r < 32; r++) begin
        ready_at[r] = 0;
        lb_m[r]     = 1'b0;
      end
      lp_m = 1'b0;
    end else begin
      if (LongDone) begin
        lp_m = 1'b0;
        if (LongDst != 0) lb_m[LongDst] = 1'b0;
      end
      if (fire && ID_Long) begin
        lp_m   = 1'b1;
        ldst_m = (ID_WrEn && ID_Dst != 0) ? int'(ID_Dst) : 0;
      end
      if (fire && ID_WrEn && ID_Dst != 0) begin
        if (ID_Long) begin
          lb_m[ID_Dst]     = 1'b1;
          ready_at[ID_Dst] = now_e;
        end else begin
          ready_at[ID_Dst] = now_e + int'(ID_Lat);
        end
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_Valid = 0; ID_UseRs = 0; ID_UseRt = 0; ID_WrEn = 0; ID_Long = 0;
    LongDone = 0; Flush = 0; ID_rs = 0; ID_rt = 0; ID_Dst = 0; LongDst = 0; ID_Lat = 0;
  endtask

  task automatic issue(input logic [4:0] dst, input logic [1:0] lat, input logic lng);
    idle();
    ID_Valid = 1; ID_WrEn = 1; ID_Dst = dst; ID_Lat = lat; ID_Long = lng;
  endtask

  task automatic consume(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt);
    idle();
    ID_Valid = 1; ID_rs = rs; ID_UseRs = urs; ID_rt = rt; ID_UseRt = urt;
  endtask

  task automatic drain();
    idle();
    Flush = 1;
    step();
    idle();
    step();
  endtask

  task automatic test_reset();
    idle();
    #2;
    consume(5, 1, 0, 0);
    #1;
    n_cmp++; if (ID_Stall !== 1'b0 || ID_Fire !== 1'b1 || LongBusy !== 1'b0) begin
      n_err++; $display("FAIL reset_held: stall=%b fire=%b busy=%b, want 0 1 0",
                        ID_Stall, ID_Fire, LongBusy); end
    rst = 0;
    issue(9, 0, 1);
    step();
    issue(5, 3, 0);
    step();
    consume(5, 1, 9, 1);
    #1;
    n_cmp++; if (ID_Stall !== 1'b1 || LongBusy !== 1'b1) begin
      n_err++; $display("FAIL reset_pre: stall=%b busy=%b, want 1 1", ID_Stall, LongBusy); end
    rst = 1;
    model_reset();
    #1;
    n_cmp++; if (ID_Stall !== 1'b0 || ID_Fire !== 1'b1 || LongBusy !== 1'b0) begin
      n_err++; $display("FAIL reset_async: stall=%b fire=%b busy=%b, want 0 1 0",
                        ID_Stall, ID_Fire, LongBusy); end
    rst = 0;
    idle();
    step();
    consume(5, 1, 9, 1);
    #1;
    n_cmp++; if (ID_Stall !== 1'b0 || LongBusy !== 1'b0) begin
      n_err++; $display("FAIL reset_after: stall=%b busy=%b, want 0 0", ID_Stall, LongBusy); end
    idle();
    step();
  endtask

  task automatic test_load_use();
    issue(8, 1, 0);
    step();
    consume(8, 1, 0, 0);
    #1;
    n_cmp++; if (ID_Stall !== 1'b1 || ID_Fire !== 1'b0) begin
      n_err++; $display("FAIL load_use_c1: stall=%b fire=%b, want 1 0", ID_Stall, ID_Fire); end
    step();
    n_cmp++; if (ID_Stall !== 1'b0 || ID_Fire !== 1'b1) begin
      n_err++; $display("FAIL load_use_c2: stall=%b fire=%b, want 0 1", ID_Stall, ID_Fire); end
    step();
    issue(8, 0, 0);
    step();
    consume(8, 1, 0, 0);
    #1;
    n_cmp++; if (ID_Stall !== 1'b0 || ID_Fire !== 1'b1) begin
      n_err++; $display("FAIL alu_use: stall=%b fire=%b, want 0 1", ID_Stall, ID_Fire); end
    step();
  endtask

  task automatic test_reg0();
    issue(0, 1, 0);
    step();
    consume(0, 1, 0, 1);
    #1;
    n_cmp++; if (ID_Stall !== 1'b0) begin
      n_err++; $display("FAIL reg0_use: stall=%b, want 0", ID_Stall); end
    step();
    issue(8, 1, 0);
    step();
    consume(8, 0, 8, 0);
    #1;
    n_cmp++; if (ID_Stall !== 1'b0) begin
      n_err++; $display("FAIL unused_src: stall=%b, want 0", ID_Stall); end
    step();
  endtask

  task automatic test_long();
    issue(9, 0, 1);
    #1;
    n_cmp++; if (ID_Fire !== 1'b1) begin
      n_err++; $display("FAIL long_issue: fire=%b, want 1", ID_Fire); end
    step();
    consume(0, 0, 9, 1);
    #1;
    n_cmp++; if (ID_Stall !== 1'b1 || LongBusy !== 1'b1) begin
      n_err++; $display("FAIL long_raw: stall=%b busy=%b, want 1 1", ID_Stall, LongBusy); end
    idle(); ID_Valid = 1; ID_Long = 1;
    #1;
    n_cmp++; if (ID_Stall !== 1'b1) begin
      n_err++; $display("FAIL long_struct: stall=%b, want 1", ID_Stall); end
    issue(9, 0, 0);
    #1;
    n_cmp++; if (ID_Stall !== 1'b1) begin
      n_err++; $display("FAIL long_waw: stall=%b, want 1", ID_Stall); end
    issue(2, 0, 0); ID_rs = 1; ID_UseRs = 1;
    #1;
    n_cmp++; if (ID_Stall !== 1'b0 || ID_Fire !== 1'b1) begin
      n_err++; $display("FAIL long_indep: stall=%b fire=%b, want 0 1", ID_Stall, ID_Fire); end
    step();
    consume(0, 0, 9, 1); LongDone = 1; LongDst = 9;
    #1;
    n_cmp++; if (ID_Stall !== 1'b1) begin
      n_err++; $display("FAIL long_done_cyc: stall=%b, want 1", ID_Stall); end
    step();
    consume(0, 0, 9, 1);
    #1;
    n_cmp++; if (ID_Stall !== 1'b0 || LongBusy !== 1'b0) begin
      n_err++; $display("FAIL long_after: stall=%b busy=%b, want 0 0", ID_Stall, LongBusy); end
    step();
  endtask

  task automatic test_flush();
    issue(9, 0, 1);
    step();
    issue(4, 1, 0);
    step();
    consume(4, 1, 9, 1); Flush = 1; LongDone = 1; LongDst = 9;
    #1;
    n_cmp++; if (ID_Fire !== 1'b0) begin
      n_err++; $display("FAIL flush_fire: fire=%b, want 0", ID_Fire); end
    step();
    consume(4, 1, 9, 1); ID_Long = 1; ID_WrEn = 1; ID_Dst = 9;
    #1;
    n_cmp++; if (ID_Stall !== 1'b0 || LongBusy !== 1'b0 || ID_Fire !== 1'b1) begin
      n_err++; $display("FAIL flush_after: stall=%b busy=%b fire=%b, want 0 0 1",
                        ID_Stall, LongBusy, ID_Fire); end
    step();
    drain();
  endtask

  task automatic test_waw();
    issue(3, 1, 0);
    step();
    issue(3, 0, 0);
    #1;
    n_cmp++; if (ID_Fire !== 1'b1) begin
      n_err++; $display("FAIL waw_issue: fire=%b, want 1", ID_Fire); end
    step();
    consume(0, 0, 3, 1);
    #1;
    n_cmp++; if (ID_Stall !== 1'b0) begin
      n_err++; $display("FAIL waw_override: stall=%b, want 0", ID_Stall); end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle();
      ID_Valid = ($urandom_range(0, 3) != 0);
      ID_rs    = 5'($urandom_range(0, 7));
      ID_rt    = 5'($urandom_range(0, 7));
      ID_UseRs = 1'($urandom_range(0, 1));
      ID_UseRt = 1'($urandom_range(0, 1));
      ID_WrEn  = ($urandom_range(0, 3) != 0);
      ID_Dst   = 5'($urandom_range(0, 7));
      ID_Lat   = 2'($urandom_range(0, 3));
      ID_Long  = ($urandom_range(0, 5) == 0);
      Flush    = ($urandom_range(0, 24) == 0);
      if (lp_m && $urandom_range(0, 3) == 0) begin
        LongDone = 1;
        LongDst  = 5'(ldst_m);
      end
      #1;
      n_cmp++; if (ID_Stall !== m_stall()) begin
        n_err++; $display("FAIL rand_stall[%0d]: got %b, want %b", i, ID_Stall, m_stall()); end
      n_cmp++; if (ID_Fire !== (ID_Valid && !m_stall() && !Flush)) begin
        n_err++; $display("FAIL rand_fire[%0d]: got %b, want %b", i, ID_Fire,
                          ID_Valid && !m_stall() && !Flush); end
      n_cmp++; if (LongBusy !== lp_m) begin
        n_err++; $display("FAIL rand_busy[%0d]: got %b, want %b", i, LongBusy, lp_m); end
      step();
    end
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    test_reset();
    test_load_use();
    test_reg0();
    test_long();
    test_flush();
    test_waw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
